// File: rtl/riscv_pkg.sv
// riscv_pkg: shared front-end types and constants for fetch and decode
package riscv_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic misalign;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: FWFT instruction queue between fetch and decode with one-cycle redirect flush
module fetch_queue #(
  parameter int DATA_WIDTH = riscv_pkg::DATA_WIDTH,
  parameter int INSTR_WIDTH = riscv_pkg::INSTR_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [INSTR_WIDTH-1:0]     in_instr_i,
  input  logic [DATA_WIDTH-1:0]      in_pc_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [INSTR_WIDTH-1:0]     out_instr_o,
  output logic [DATA_WIDTH-1:0]      out_pc_o,
  output logic                       out_misalign_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  riscv_pkg::fetch_entry_t mem [DEPTH];
  riscv_pkg::fetch_entry_t head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push, pop;
  assign in_ready_o = count != CW'(DEPTH);
  assign out_valid_o = count != '0;
  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop = out_valid_o & out_ready_i & ~flush_i;
  assign head = mem[rd_ptr];
  assign out_instr_o = out_valid_o ? head.instr : riscv_pkg::NOP_INSTR;
  assign out_pc_o = out_valid_o ? head.pc : '0;
  assign out_misalign_o = out_valid_o & head.misalign;
  assign count_o = count;
  // storage is deliberately unreset; only pointers and count define validity
  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= '{pc: in_pc_i, instr: in_instr_i, misalign: |in_pc_i[1:0]};
  // pointer and occupancy update; flush wins over any same-cycle push or pop
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule
